// File: rtl/conv_sequencer.sv
// Control FSM for a valid (no-padding) KxK convolution: issues window reads,
// steers an external MAC (clear/accumulate/coefficient index) and write-backs.
module conv_sequencer #(
  parameter int unsigned IMG_W    = 8,
  parameter int unsigned IMG_H    = 8,
  parameter int unsigned K        = 3,
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned IN_BASE  = 0,
  parameter int unsigned OUT_BASE = 256,
  localparam int unsigned KW      = $clog2(K * K)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              mac_clr,
  output logic              mac_acc,
  output logic [KW-1:0]     k_idx
);

  localparam int unsigned OW = IMG_W - K + 1;
  localparam int unsigned OH = IMG_H - K + 1;
  localparam int unsigned XW = $clog2(IMG_W);
  localparam int unsigned YW = $clog2(IMG_H);
  localparam int unsigned CW = $clog2(K);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FETCH, S_DRAIN, S_WRITE, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [XW-1:0]   ox_q, ox_d;
  logic [YW-1:0]   oy_q, oy_d;
  logic [CW-1:0]   kx_q, kx_d, ky_q, ky_d;
  logic            mac_acc_q;
  logic [KW-1:0]   k_idx_q;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic [KW-1:0]   cur_idx;

  assign rd_addr = ADDR_W'(IN_BASE)
                 + (ADDR_W'(oy_q) + ADDR_W'(ky_q)) * ADDR_W'(IMG_W)
                 + ADDR_W'(ox_q) + ADDR_W'(kx_q);
  assign wr_addr = ADDR_W'(OUT_BASE) + ADDR_W'(oy_q) * ADDR_W'(OW) + ADDR_W'(ox_q);
  assign cur_idx = KW'(ky_q) * KW'(K) + KW'(kx_q);

  assign mac_acc = mac_acc_q;
  assign k_idx   = k_idx_q;

  always_comb begin
    state_d  = state_q;
    ox_d     = ox_q;
    oy_d     = oy_q;
    kx_d     = kx_q;
    ky_d     = ky_q;
    busy     = (state_q != S_IDLE) && (state_q != S_DONE);
    done     = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    mac_clr  = 1'b0;
    mem_addr = '0;
    // Every state only acts while enabled, so a stall freezes state and counters.
    case (state_q)
      S_IDLE: begin
        if (en && start) begin
          state_d = S_CLEAR;
          ox_d    = '0;
          oy_d    = '0;
          kx_d    = '0;
          ky_d    = '0;
        end
      end
      S_CLEAR: begin
        if (en) begin
          mac_clr = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (en) begin
          mem_rd   = 1'b1;
          mem_addr = rd_addr;
          if (kx_q == CW'(K - 1)) begin
            kx_d = '0;
            if (ky_q == CW'(K - 1)) begin
              ky_d    = '0;
              state_d = S_DRAIN;
            end else begin
              ky_d = ky_q + CW'(1);
            end
          end else begin
            kx_d = kx_q + CW'(1);
          end
        end
      end
      S_DRAIN: begin
        if (en) state_d = S_WRITE;
      end
      S_WRITE: begin
        if (en) begin
          mem_wr   = 1'b1;
          mem_addr = wr_addr;
          state_d  = S_CLEAR;
          if (ox_q == XW'(OW - 1)) begin
            ox_d = '0;
            if (oy_q == YW'(OH - 1)) begin
              oy_d    = '0;
              state_d = S_DONE;
            end else begin
              oy_d = oy_q + YW'(1);
            end
          end else begin
            ox_d = ox_q + XW'(1);
          end
        end
      end
      S_DONE: begin
        if (en) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The accumulate strobe trails the gated read strobe, so it still fires
  // in a stalled cycle that follows a read.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ox_q      <= '0;
      oy_q      <= '0;
      kx_q      <= '0;
      ky_q      <= '0;
      mac_acc_q <= 1'b0;
      k_idx_q   <= '0;
    end else begin
      state_q   <= state_d;
      ox_q      <= ox_d;
      oy_q      <= oy_d;
      kx_q      <= kx_d;
      ky_q      <= ky_d;
      mac_acc_q <= mem_rd;
      k_idx_q   <= mem_rd ? cur_idx : '0;
    end
  end

endmodule

// File: tb/tb_conv_sequencer.sv
// Bench for conv_sequencer: memory/MAC environment plus a direct convolution
// reference; default 8x8/K=3 instance and a 3x3/K=3 single-pixel instance.
module tb_conv_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, start;
  logic        busy, done, mem_rd, mem_wr, mac_clr, mac_acc;
  logic [15:0] mem_addr;
  logic [3:0]  k_idx;

  logic        en2, start2;
  logic        busy2, done2, mem_rd2, mem_wr2, mac_clr2, mac_acc2;
  logic [15:0] mem_addr2;
  logic [3:0]  k_idx2;

  conv_sequencer dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .busy(busy), .done(done),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mac_clr(mac_clr),
    .mac_acc(mac_acc), .k_idx(k_idx)
  );

  conv_sequencer #(.IMG_W(3), .IMG_H(3), .K(3)) dut_small (
    .clk(clk), .rst(rst), .en(en2), .start(start2), .busy(busy2), .done(done2),
    .mem_addr(mem_addr2), .mem_rd(mem_rd2), .mem_wr(mem_wr2), .mac_clr(mac_clr2),
    .mac_acc(mac_acc2), .k_idx(k_idx2)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int asserts = 0, fails = 0;
  int img [0:1023];
  int coef [0:15];
  int wa[$], wv[$], rd_a[$], rd_c[$], ac_k[$], ac_c[$], clr_c[$];
  int exp_a[$], exp_v[$];
  int stall_q[$];
  int done_count = 0, last_done = 0, proto_err = 0, acc = 0, rdata = 0;
  int t0;
  int w2a[$], w2v[$];
  int done2_n = 0, done2_cyc = 0, acc2 = 0, rdata2 = 0;

  // Memory + MAC environment: read data returns one cycle after mem_rd.
  always @(negedge clk) begin
    if (mac_clr) acc = 0;
    if (mac_acc) begin
      acc = acc + rdata * coef[k_idx];
      ac_k.push_back(int'(k_idx));
      ac_c.push_back(cyc);
    end
    if (mac_clr) clr_c.push_back(cyc);
    if (mem_wr) begin
      wa.push_back(int'(mem_addr));
      wv.push_back(acc);
    end
    if (mem_rd) begin
      rd_a.push_back(int'(mem_addr));
      rd_c.push_back(cyc);
    end
    if (done) begin
      done_count++;
      last_done = cyc;
    end
    if (mem_rd && mem_wr) proto_err++;
    if (!mem_rd && !mem_wr && mem_addr != 16'd0) proto_err++;
    rdata = mem_rd ? img[mem_addr[9:0]] : 0;
  end

  always @(negedge clk) begin
    if (mac_clr2) acc2 = 0;
    if (mac_acc2) acc2 = acc2 + rdata2;
    if (mem_wr2) begin
      w2a.push_back(int'(mem_addr2));
      w2v.push_back(acc2);
    end
    if (done2) begin
      done2_n++;
      done2_cyc = cyc;
    end
    rdata2 = mem_rd2 ? int'(mem_addr2) : 0;
  end

  function automatic void fill_ramp();
    for (int a = 0; a < 1024; a++) img[a] = a;
    for (int i = 0; i < 16; i++) coef[i] = 1;
  endfunction

  function automatic void fill_random();
    for (int a = 0; a < 1024; a++) img[a] = int'($urandom_range(0, 255));
    for (int i = 0; i < 16; i++) coef[i] = int'($urandom_range(0, 15));
  endfunction

  // Direct definition of a valid 3x3 convolution over the 8x8 frame.
  function automatic void build_model();
    exp_a.delete();
    exp_v.delete();
    for (int oy = 0; oy < 6; oy++)
      for (int ox = 0; ox < 6; ox++) begin
        int s = 0;
        for (int ky = 0; ky < 3; ky++)
          for (int kx = 0; kx < 3; kx++)
            s += img[(oy + ky) * 8 + ox + kx] * coef[ky * 3 + kx];
        exp_a.push_back(256 + oy * 6 + ox);
        exp_v.push_back(s);
      end
  endfunction

  function automatic int first_write_error();
    if (wa.size() != exp_a.size()) return -2;
    foreach (wa[i])
      if (wa[i] != exp_a[i] || wv[i] != exp_v[i]) return i;
    return -1;
  endfunction

  task automatic run_frame(input bit hold, output int lat, output bit to);
    int dc0, rel;
    @(posedge clk); #1;
    wa.delete(); wv.delete(); rd_a.delete(); rd_c.delete();
    ac_k.delete(); ac_c.delete(); clr_c.delete();
    dc0 = done_count;
    t0 = cyc;
    start = 1'b1;
    en = 1'b1;
    to = 1'b0;
    while (1) begin
      @(posedge clk); #1;
      if (done_count > dc0) break;
      rel = cyc - t0;
      if (rel > 3000) begin
        to = 1'b1;
        break;
      end
      if (!hold) start = 1'b0;
      en = 1'b1;
      foreach (stall_q[i])
        if (rel >= stall_q[i] && rel < stall_q[i] + 3) en = 1'b0;
    end
    lat = last_done - t0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; start = 1'b0; en2 = 1'b0; start2 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    asserts++;
    if ({busy, done, mem_rd, mem_wr, mac_clr, mac_acc, mem_addr, k_idx} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got busy=%b done=%b rd=%b wr=%b clr=%b acc=%b addr=%0d k=%0d, want all 0",
               busy, done, mem_rd, mem_wr, mac_clr, mac_acc, mem_addr, k_idx);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    asserts++;
    if ({busy, done, mem_rd, mem_wr, mac_clr, mac_acc, mem_addr, k_idx,
         busy2, done2, mem_rd2, mem_wr2, mac_clr2, mac_acc2, mem_addr2, k_idx2} !== '0) begin
      fails++;
      $display("FAIL idle_outputs: got busy=%b rd=%b wr=%b addr=%0d busy2=%b addr2=%0d, want all 0",
               busy, mem_rd, mem_wr, mem_addr, busy2, mem_addr2);
    end
  endtask

  task automatic test_ramp_frame();
    int lat, bad;
    bit to;
    fill_ramp();
    build_model();
    run_frame(1'b0, lat, to);
    asserts++;
    if (to || lat != 433) begin
      fails++;
      $display("FAIL ramp_latency: got %0d (timeout=%b), want 433", lat, to);
    end
    asserts++;
    if (wa.size() != 36) begin
      fails++;
      $display("FAIL ramp_write_count: got %0d, want 36", wa.size());
    end
    asserts++;
    if (wa.size() < 36 || wa[0] != 256 || wv[0] != 81 || wa[35] != 291) begin
      fails++;
      $display("FAIL ramp_first_last: got first %0d=%0d last %0d, want 256=81 last 291",
               wa.size() > 0 ? wa[0] : -1, wv.size() > 0 ? wv[0] : -1,
               wa.size() > 0 ? wa[wa.size() - 1] : -1);
    end
    asserts++;
    bad = first_write_error();
    if (bad != -1) begin
      fails++;
      $display("FAIL ramp_writes: first bad entry %0d (-2 = count), got %0d writes, want %0d",
               bad, wa.size(), exp_a.size());
    end
    bad = 0;
    for (int i = 0; i < 9; i++) begin
      if (rd_a.size() <= i || rd_a[i] != (i / 3) * 8 + i % 3 || rd_c[i] != t0 + 2 + i) bad++;
      if (ac_k.size() <= i || ac_k[i] != i || ac_c[i] != t0 + 3 + i) bad++;
    end
    asserts++;
    if (bad != 0) begin
      fails++;
      $display("FAIL first_pixel_trace: got %0d bad read/acc events, want 0", bad);
    end
    asserts++;
    if (clr_c.size() != 36 || clr_c[0] != t0 + 1) begin
      fails++;
      $display("FAIL mac_clr_pulses: got %0d pulses first at +%0d, want 36 first at +1",
               clr_c.size(), clr_c.size() > 0 ? clr_c[0] - t0 : -1);
    end
  endtask

  task automatic test_random_frame();
    int lat, bad;
    bit to;
    fill_random();
    build_model();
    run_frame(1'b0, lat, to);
    bad = first_write_error();
    asserts++;
    if (to || lat != 433 || bad != -1) begin
      fails++;
      $display("FAIL random_frame: got latency %0d bad entry %0d, want 433 and -1", lat, bad);
    end
  endtask

  task automatic test_stall();
    int lat, bad, p1, p2, p3, r;
    bit to;
    fill_random();
    build_model();
    p1 = int'($urandom_range(0, 10));
    p2 = int'($urandom_range(12, 22));
    p3 = int'($urandom_range(24, 34));
    r  = int'($urandom_range(1, 7));
    // Nominal positions shifted by the 3 cycles each earlier stall adds.
    stall_q = '{12 * p1 + 2 + r, 12 * p2 + 11 + 3, 12 * p3 + 12 + 6};
    run_frame(1'b0, lat, to);
    stall_q.delete();
    bad = first_write_error();
    asserts++;
    if (bad != -1) begin
      fails++;
      $display("FAIL stall_writes: first bad entry %0d, got %0d writes, want 36 matching", bad, wa.size());
    end
    asserts++;
    if (to || lat != 442) begin
      fails++;
      $display("FAIL stall_latency: got %0d, want 442", lat);
    end
  endtask

  task automatic test_reset_midframe();
    int dc0, lat, bad;
    bit to;
    fill_random();
    build_model();
    @(posedge clk); #1;
    wa.delete(); wv.delete();
    t0 = cyc;
    start = 1'b1;
    en = 1'b1;
    for (int rel = 1; rel <= 120; rel++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (rel == 120) rst = 1'b1;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    asserts++;
    if (wa.size() != 10) begin
      fails++;
      $display("FAIL reset_at_10th_write: got %0d writes before reset, want 10", wa.size());
    end
    @(negedge clk);
    asserts++;
    if ({busy, done, mem_rd, mem_wr, mac_clr, mac_acc, mem_addr, k_idx} !== '0) begin
      fails++;
      $display("FAIL reset_midframe_outputs: got busy=%b wr=%b rd=%b addr=%0d, want all 0",
               busy, mem_wr, mem_rd, mem_addr);
    end
    dc0 = done_count;
    repeat (40) @(posedge clk);
    #1;
    asserts++;
    if (wa.size() != 10 || done_count != dc0) begin
      fails++;
      $display("FAIL reset_quiet: got %0d writes, %0d dones, want 10 and 0", wa.size(), done_count - dc0);
    end
    run_frame(1'b0, lat, to);
    bad = first_write_error();
    asserts++;
    if (to || lat != 433 || bad != -1 || wa.size() < 1 || wa[0] != 256) begin
      fails++;
      $display("FAIL restart_after_reset: got latency %0d bad %0d first %0d, want 433, -1, 256",
               lat, bad, wa.size() > 0 ? wa[0] : -1);
    end
  endtask

  task automatic test_start_held();
    int lat, dc0, n;
    bit to;
    fill_ramp();
    dc0 = done_count;
    run_frame(1'b1, lat, to);
    asserts++;
    if (to || lat != 433 || wa.size() != 36 || done_count != dc0 + 1) begin
      fails++;
      $display("FAIL start_held_frame: got latency %0d writes %0d dones %0d, want 433, 36, 1",
               lat, wa.size(), done_count - dc0);
    end
    @(negedge clk);
    asserts++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL start_held_idle: got busy=%b, want 0", busy);
    end
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    asserts++;
    if (busy !== 1'b1 || mac_clr !== 1'b1) begin
      fails++;
      $display("FAIL start_held_restart: got busy=%b mac_clr=%b, want 1 1", busy, mac_clr);
    end
    dc0 = done_count;
    n = 0;
    while (done_count == dc0 && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    asserts++;
    if (done_count != dc0 + 1) begin
      fails++;
      $display("FAIL start_held_second_done: got %0d dones within 1000 cycles, want 1", done_count - dc0);
    end
  endtask

  task automatic test_small_frame();
    int n, dc0, st;
    @(posedge clk); #1;
    w2a.delete(); w2v.delete();
    dc0 = done2_n;
    st = cyc;
    start2 = 1'b1;
    en2 = 1'b1;
    n = 0;
    while (done2_n == dc0 && n < 100) begin
      @(posedge clk); #1;
      start2 = 1'b0;
      n++;
    end
    asserts++;
    if (done2_n != dc0 + 1 || done2_cyc - st != 13) begin
      fails++;
      $display("FAIL small_latency: got %0d (dones %0d), want 13", done2_cyc - st, done2_n - dc0);
    end
    asserts++;
    if (w2a.size() != 1 || w2a[0] != 256 || w2v[0] != 36) begin
      fails++;
      $display("FAIL small_write: got %0d writes first %0d=%0d, want 1 write 256=36",
               w2a.size(), w2a.size() > 0 ? w2a[0] : -1, w2v.size() > 0 ? w2v[0] : -1);
    end
  endtask

  initial begin
    test_reset();
    test_ramp_frame();
    test_random_frame();
    test_stall();
    test_reset_midframe();
    test_start_held();
    test_small_frame();
    asserts++;
    if (proto_err != 0) begin
      fails++;
      $display("FAIL strobe_protocol: got %0d violations, want 0", proto_err);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
